// File: rtl/s298_harness_pkg.sv
// Shared types and constants for the s298 attack harness.
// resp bit order is {G133,G132,G118,G117,G67,G66}.
package s298_harness_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSkipping,
        StCapture,
        StDone
    } misr_state_e;

    localparam int unsigned RESP_W_DEF = 6;
    localparam int unsigned SIG_W_DEF  = 16;
    localparam logic [15:0] POLY_CCITT = 16'h1021;

    localparam int unsigned G66_BIT  = 0;
    localparam int unsigned G67_BIT  = 1;
    localparam int unsigned G117_BIT = 2;
    localparam int unsigned G118_BIT = 3;
    localparam int unsigned G132_BIT = 4;
    localparam int unsigned G133_BIT = 5;

endpackage

// File: rtl/misr_step.sv
// One Galois MISR update: shift left, fold in poly on carry-out, xor in the response.
// Purely combinational so the stimulus LFSR can reuse it with a zero response.
module misr_step #(
    parameter int unsigned SIG_W  = 16,
    parameter int unsigned RESP_W = 6
) (
    input  logic [SIG_W-1:0]  sig_i,
    input  logic [RESP_W-1:0] resp_i,
    input  logic [SIG_W-1:0]  poly_i,
    output logic [SIG_W-1:0]  next_o
);

    always_comb begin
        next_o = {sig_i[SIG_W-2:0], 1'b0} ^ (sig_i[SIG_W-1] ? poly_i : '0) ^ SIG_W'(resp_i);
    end

endmodule

// File: rtl/s298_resp_misr.sv
// Response compactor for the s298 core: skip settling cycles, fold CYCLES responses
// into a MISR, hold the signature under a ready/ack handshake. Optional MISR_COMPARE_EN.
module s298_resp_misr
    import s298_harness_pkg::*;
#(
    parameter int unsigned      RESP_W = RESP_W_DEF,
    parameter int unsigned      SIG_W  = SIG_W_DEF,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(POLY_CCITT),
    parameter logic [SIG_W-1:0] SEED   = '0,
    parameter int unsigned      SKIP   = 2,
    parameter int unsigned      CYCLES = 64
) (
    input  logic              CK,
    input  logic              RN,
    input  logic              start,
    input  logic [RESP_W-1:0] resp,
    output logic              busy,
    output logic              sig_ready,
    input  logic              sig_ack,
`ifdef MISR_COMPARE_EN
    input  logic [SIG_W-1:0]  sig_golden,
    output logic              sig_match,
`endif
    output logic [SIG_W-1:0]  sig
);

    localparam int unsigned CNT_MAX = (SKIP > CYCLES) ? SKIP : CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SKIP_LAST   = CNT_W'((SKIP == 0) ? 0 : SKIP - 1);
    localparam logic [CNT_W-1:0] CYCLES_LAST = CNT_W'(CYCLES - 1);

    misr_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [SIG_W-1:0] sig_step;

    misr_step #(
        .SIG_W  (SIG_W),
        .RESP_W (RESP_W)
    ) u_step (
        .sig_i  (sig_q),
        .resp_i (resp),
        .poly_i (POLY),
        .next_o (sig_step)
    );

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sig_q   <= SEED;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sig_q   <= sig_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sig_d   = sig_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    sig_d   = SEED;
                    cnt_d   = '0;
                    state_d = (SKIP > 0) ? StSkipping : StCapture;
                end
            end
            StSkipping: begin
                if (cnt_q == SKIP_LAST) begin
                    cnt_d   = '0;
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCapture: begin
                sig_d = sig_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CYCLES_LAST) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // start is deliberately ignored here, even alongside ack
                if (sig_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy      = (state_q == StSkipping) || (state_q == StCapture);
        sig_ready = (state_q == StDone);
    end

    assign sig = sig_q;

`ifdef MISR_COMPARE_EN
    assign sig_match = sig_ready && (sig_q == sig_golden);
`endif

endmodule

// File: tb/tb_s298_resp_misr.sv
// Directed bench for s298_resp_misr: three instances covering settling latency,
// single-bit walks with the handshake, and polynomial feedback.
module tb_s298_resp_misr;

    logic CK = 1'b0;
    logic RN = 1'b0;

    always #5 CK = ~CK;

    logic        z_start = 0, z_ack = 0, z_busy, z_ready;
    logic [5:0]  z_resp = '0;
    logic [15:0] z_sig;
    logic        w_start = 0, w_ack = 0, w_busy, w_ready;
    logic [5:0]  w_resp = '0;
    logic [15:0] w_sig;
    logic        f_start = 0, f_ack = 0, f_busy, f_ready;
    logic [5:0]  f_resp = '0;
    logic [15:0] f_sig;
`ifdef MISR_COMPARE_EN
    logic [15:0] z_gold = '0, w_gold = '0, f_gold = '0;
    logic        z_match, w_match, f_match;
`endif

    s298_resp_misr #(.SKIP(2), .CYCLES(64), .SEED(16'h0000)) u_zero (
        .CK        (CK),
        .RN        (RN),
        .start     (z_start),
        .resp      (z_resp),
        .busy      (z_busy),
        .sig_ready (z_ready),
        .sig_ack   (z_ack),
`ifdef MISR_COMPARE_EN
        .sig_golden(z_gold),
        .sig_match (z_match),
`endif
        .sig       (z_sig)
    );

    s298_resp_misr #(.SKIP(0), .CYCLES(2), .SEED(16'h0000)) u_walk (
        .CK        (CK),
        .RN        (RN),
        .start     (w_start),
        .resp      (w_resp),
        .busy      (w_busy),
        .sig_ready (w_ready),
        .sig_ack   (w_ack),
`ifdef MISR_COMPARE_EN
        .sig_golden(w_gold),
        .sig_match (w_match),
`endif
        .sig       (w_sig)
    );

    s298_resp_misr #(.SKIP(0), .CYCLES(1), .SEED(16'h8000)) u_fb (
        .CK        (CK),
        .RN        (RN),
        .start     (f_start),
        .resp      (f_resp),
        .busy      (f_busy),
        .sig_ready (f_ready),
        .sig_ack   (f_ack),
`ifdef MISR_COMPARE_EN
        .sig_golden(f_gold),
        .sig_match (f_match),
`endif
        .sig       (f_sig)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    initial begin
        int cnt;

        repeat (2) tick();
        check("rst_busy", 32'(z_busy), 32'd0);
        check("rst_ready", 32'(z_ready), 32'd0);
        check("rst_sig", 32'(z_sig), 32'h0000);
        check("rst_seed_fb", 32'(f_sig), 32'h8000);
        RN = 1'b1;
        tick();

        // Zero response: ready exactly SKIP+CYCLES edges after the accepting edge
        z_start = 1;
        tick();
        z_start = 0;
        check("zero_busy", 32'(z_busy), 32'd1);
        cnt = 0;
        while (!z_ready && cnt < 200) begin
            tick();
            cnt++;
        end
        check("zero_latency", 32'(cnt), 32'd66);
        check("zero_sig", 32'(z_sig), 32'h0000);
        z_ack = 1;
        tick();
        z_ack = 0;
        check("zero_ack_idle", 32'(z_ready), 32'd0);

        // Walk 01 then 00; ack during CAPTURE must be ignored
        w_start = 1;
        tick();
        w_start = 0;
        w_ack   = 1;
        w_resp  = 6'h01;
        tick();
        check("walk_mid_ready", 32'(w_ready), 32'd0);
        check("walk_mid_busy", 32'(w_busy), 32'd1);
        w_ack  = 0;
        w_resp = 6'h00;
        tick();
        check("walk_a_ready", 32'(w_ready), 32'd1);
        check("walk_a_sig", 32'(w_sig), 32'h0002);
`ifdef MISR_COMPARE_EN
        w_gold = 16'h0002;
        #1;
        check("cmp_match_done", 32'(w_match), 32'd1);
        w_gold = 16'h0003;
        #1;
        check("cmp_one_bit_off", 32'(w_match), 32'd0);
        w_gold = 16'h0002;
`endif

        // Hold DONE with no ack; a start in the middle is ignored
        for (int i = 0; i < 10; i++) begin
            w_start = (i == 4);
            tick();
            check("hold_sig", 32'(w_sig), 32'h0002);
            check("hold_ready", 32'(w_ready), 32'd1);
        end
        w_start = 0;

        // start together with ack: ack wins, start ignored
        w_start = 1;
        w_ack   = 1;
        tick();
        w_start = 0;
        w_ack   = 0;
        check("ack_ready", 32'(w_ready), 32'd0);
        check("ack_busy", 32'(w_busy), 32'd0);
        check("ack_sig_kept", 32'(w_sig), 32'h0002);
`ifdef MISR_COMPARE_EN
        check("cmp_idle", 32'(w_match), 32'd0);
`endif
        tick();
        w_start = 1;
        tick();
        w_start = 0;
        check("restart_busy", 32'(w_busy), 32'd1);
        check("restart_seed", 32'(w_sig), 32'h0000);
        w_resp = 6'h00;
        tick();
        w_resp = 6'h01;
        tick();
        w_resp = 6'h00;
        check("walk_b_ready", 32'(w_ready), 32'd1);
        check("walk_b_sig", 32'(w_sig), 32'h0001);

        // Feedback: seed MSB set forces polynomial fold
        f_start = 1;
        tick();
        f_start = 0;
        f_resp  = 6'h3F;
        tick();
        check("fb_ready", 32'(f_ready), 32'd1);
        check("fb_sig", 32'(f_sig), 32'h101E);

        // Asynchronous reset in the middle of CAPTURE
        z_start = 1;
        tick();
        z_start = 0;
        z_resp  = 6'h3F;
        repeat (8) tick();
        check("pre_rst_busy", 32'(z_busy), 32'd1);
        check("pre_rst_sig_nonzero", 32'(z_sig != 16'h0000), 32'd1);
        RN = 1'b0;
        #1;
        check("arst_busy", 32'(z_busy), 32'd0);
        check("arst_ready", 32'(z_ready), 32'd0);
        check("arst_sig", 32'(z_sig), 32'h0000);
        tick();
        RN = 1'b1;
        z_resp = '0;
        repeat (5) tick();
        check("post_rst_ready", 32'(z_ready), 32'd0);
        check("post_rst_busy", 32'(z_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/s298_resp_misr.md
Name: s298_resp_misr

Overview:
- Downstream response compactor for the s298 sequential core, on the same clock.
- Consumes the six primary outputs G66, G67, G117, G118, G132 and G133 each cycle while a capture window is open.
- Folds them into a multiple-input signature register (MISR) and presents the final signature through a ready/ack handshake.
- Used by the attack harness to compare keyed against oracle behaviour without storing full output traces.

Parameters:
- RESP_W, 6, response width; bit order {G133,G132,G118,G117,G67,G66}, so G66 is bit 0.
- SIG_W, 16, signature width; must satisfy SIG_W >= RESP_W.
- POLY, 16'h1021, Galois feedback polynomial; the x^SIG_W term is implicit.
- SEED, 16'h0000, signature value loaded when a window starts.
- SKIP, 2, cycles discarded after start (core settling); 0 is legal.
- CYCLES, 64, number of captured cycles; must be >= 1.

Ports:
- CK  in  1  clock, rising edge.
- RN  in  1  asynchronous active-low reset.
- start  in  1  begins a window; honoured only in IDLE.
- resp  in  RESP_W  core primary outputs, sampled on every CAPTURE cycle.
- busy  out  1  high in SKIPPING or CAPTURE.
- sig_ready  out  1  high in DONE.
- sig_ack  in  1  consumer acknowledge; honoured only in DONE.
- sig  out  SIG_W  signature register; stable throughout DONE.

Behaviour:
- Reset (RN low, asynchronous): state=IDLE, sig=SEED, counter=0, busy=0, sig_ready=0. Release is synchronous to the next CK edge.
- States: IDLE, SKIPPING, CAPTURE, DONE.
- IDLE, start=1:
  - sig<=SEED, counter<=0.
  - Go to SKIPPING if SKIP>0, otherwise directly to CAPTURE.
- SKIPPING:
  - counter increments each cycle; resp is ignored.
  - When counter==SKIP-1: counter<=0, go to CAPTURE.
- CAPTURE, every cycle:
  - sig <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero-extended resp.
  - counter increments.
  - On the CYCLES-th update (counter==CYCLES-1), go to DONE.
- Latency: exactly SKIP+CYCLES cycles from the start-accepting edge to sig_ready=1. sig is final on the first DONE cycle.
- DONE:
  - sig and sig_ready are held.
  - sig_ack=1 returns to IDLE; sig keeps its value until the next start.
- Edge cases:
  - start outside IDLE is ignored, including start in DONE on the same cycle as ack.
  - sig_ack outside DONE is ignored.
- Reset mid-window aborts immediately with no partial signature flagged.
- Counter width is clog2(max(SKIP,CYCLES)+1). The counter never wraps because state changes at the terminal count.
- X on resp during CAPTURE propagates into sig. No masking is applied.

Optional Feature:
- Macro MISR_COMPARE_EN.
- When defined:
  - Adds input sig_golden[SIG_W] and output sig_match.
  - sig_match = (sig==sig_golden) && sig_ready, combinational.
  - sig_match is 0 outside DONE and is reset to 0.
- When undefined: neither port exists, and there is no comparator logic.

Decomposition:
- Package s298_harness_pkg holds:
  - the state enum (IDLE, SKIPPING, CAPTURE, DONE);
  - RESP_W_DEF=6, SIG_W_DEF=16, POLY_CCITT=16'h1021;
  - the resp bit-order constants for each G-output.
- One sub-module, misr_step: purely combinational next-signature function (sig, resp, POLY -> next).
  - Reusable by the upstream stimulus LFSR.
  - The top holds the FSM, counter and register.

Test Plan:
- Reset state: RN low mid-CAPTURE -> busy=0, sig_ready=0 and sig=SEED within the same cycle. After release, no sig_ready until a new start.
- Zero response, SEED=0, SKIP=2, CYCLES=64, resp=0 throughout -> sig_ready rises exactly 66 cycles after start, with sig=16'h0000.
- Single-bit walk, SKIP=0, CYCLES=2, resp=6'h01 then 6'h00 -> sig=16'h0002. With resp=6'h00 then 6'h01 -> sig=16'h0001.
- Feedback, SKIP=0, CYCLES=1, SEED=16'h8000, resp=6'h3F -> sig=16'h1021^16'h003F=16'h101E.
- Handshake:
  - Hold sig_ack=0 for 10 DONE cycles -> sig stable and sig_ready=1 throughout.
  - Assert start during DONE -> ignored.
  - sig_ack=1 -> IDLE next cycle.
  - A start two cycles later opens a new window from SEED.
- MISR_COMPARE_EN: sig_golden equal to the expected 16'h0002 in the single-bit-walk case -> sig_match=1 only during DONE. A golden value differing in one bit -> sig_match=0.
